vedic16_seq_ctrl: RTL

Multi-cycle sequencer computing a 16x16 unsigned product by time-sharing a single `vedic8x8` multiplier over four partial-product cycles. It accumulates the partial products into a 32-bit result. It sits between an upstream operand source and a downstream result consumer, each with a valid/ready handshake. It is the first step in scaling the 8x8 Vedic datapath to wider operands without replicating multipliers.

---
 rtl/vedic_pkg.sv | 17 +
 rtl/vedic8x8.sv | 20 ++
 rtl/vedic16_seq_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared widths and sequencer state encoding for the Vedic multiplier family
package vedic_pkg;

  localparam int VEDIC_OP_W   = 16;
  localparam int VEDIC_HALF_W = 8;
  localparam int VEDIC_RES_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    PP0,
    PP1,
    PP2,
    PP3,
    DONE
  } vseq_state_t;

endpackage

// File: rtl/vedic8x8.sv
// rtl/vedic8x8.sv - combinational 8x8 unsigned multiplier built from four 4x4 crosswise products
module vedic8x8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  logic [7:0]  ll, hl, lh, hh;
  logic [15:0] mid;

  assign ll  = {4'b0, a_i[3:0]} * {4'b0, b_i[3:0]};
  assign hl  = {4'b0, a_i[7:4]} * {4'b0, b_i[3:0]};
  assign lh  = {4'b0, a_i[3:0]} * {4'b0, b_i[7:4]};
  assign hh  = {4'b0, a_i[7:4]} * {4'b0, b_i[7:4]};

  // Crosswise terms sum to at most 9 bits, so the 12-bit slice is lossless.
  assign mid = {8'b0, hl} + {8'b0, lh};
  assign p_o = {hh, ll} + {mid[11:0], 4'b0};

endmodule

// File: rtl/vedic16_seq_ctrl.sv
// rtl/vedic16_seq_ctrl.sv - 16x16 multiply over four shared-8x8 cycles; VEDIC16_SEQ_EARLY_ZERO_EN skips zero operands
module vedic16_seq_ctrl
  import vedic_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VEDIC_OP_W-1:0]  a,
  input  logic [VEDIC_OP_W-1:0]  b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VEDIC_RES_W-1:0] product,
  output logic                   busy
);

  vseq_state_t             state_q, state_d;
  logic [VEDIC_OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [VEDIC_RES_W-1:0]  acc_q, acc_d;
  logic [VEDIC_HALF_W-1:0] mul_a, mul_b;
  logic [2*VEDIC_HALF_W-1:0] pp;
  logic                    accept;

  always_comb begin
    mul_a = a_q[VEDIC_HALF_W-1:0];
    mul_b = b_q[VEDIC_HALF_W-1:0];
    case (state_q)
      PP1: mul_a = a_q[VEDIC_OP_W-1:VEDIC_HALF_W];
      PP2: mul_b = b_q[VEDIC_OP_W-1:VEDIC_HALF_W];
      PP3: begin
        mul_a = a_q[VEDIC_OP_W-1:VEDIC_HALF_W];
        mul_b = b_q[VEDIC_OP_W-1:VEDIC_HALF_W];
      end
      default: ;
    endcase
  end

  vedic8x8 u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (pp)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = acc_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    if (accept) begin
      a_d = a;
      b_d = b;
    end
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = PP0;
`ifdef VEDIC16_SEQ_EARLY_ZERO_EN
          if ((a == '0) || (b == '0)) begin
            state_d = DONE;
            acc_d   = '0;
          end
`endif
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      PP0: begin
        acc_d   = {16'b0, pp};
        state_d = PP1;
      end
      PP1: begin
        acc_d   = acc_q + {8'b0, pp, 8'b0};
        state_d = PP2;
      end
      PP2: begin
        acc_d   = acc_q + {8'b0, pp, 8'b0};
        state_d = PP3;
      end
      PP3: begin
        acc_d   = acc_q + {pp, 16'b0};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

endmodule
